// File: rtl/jump_exec_unit_pkg.sv
// rtl/jump_exec_unit_pkg.sv - shared jump encodings, state type and constants
//
// Purpose: jump_control encodings (`JAL / `JALR), FSM state type and the link
// offset shared by jump_exec_unit and jump_target_calc.
// Ports: none (package).

`ifndef JUMP_EXEC_UNIT_DEFS
`define JUMP_EXEC_UNIT_DEFS
`define JAL  2'b01
`define JALR 2'b10
`endif

package jump_exec_unit_pkg;

  localparam logic [31:0] LINK_OFFSET = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TRAP = 2'd2
  } jump_state_t;

  // Any encoding other than JAL/JALR is a no-op that is accepted and dropped.
  function automatic logic is_jump(input logic [1:0] ctrl);
    return (ctrl == `JAL) || (ctrl == `JALR);
  endfunction

endpackage

// File: rtl/jump_target_calc.sv
// rtl/jump_target_calc.sv - combinational jump target and link computation
//
// Purpose: computes the jump target (JAL: pc + sext(imm[20:0]);
// JALR: (rs1 + sext(imm[11:0])) with bit 0 cleared) and the link pc + 4.
// All arithmetic wraps modulo 2^XLEN.
// Ports:
//   pc, rs1_val, imm, jump_control : decoded jump operands
//   target, link                   : computed addresses
//   misaligned                     : target bit 1 set (JUMP_ALIGN_CHECK_EN only)
// Config macro: JUMP_ALIGN_CHECK_EN adds the misaligned output.

module jump_target_calc
  import jump_exec_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [20:0]     imm,
  input  logic [1:0]      jump_control,
  output logic [XLEN-1:0] target,
`ifdef JUMP_ALIGN_CHECK_EN
  output logic            misaligned,
`endif
  output logic [XLEN-1:0] link
);

  logic [XLEN-1:0] jal_target;
  logic [XLEN-1:0] jalr_sum;

  assign jal_target = pc + {{(XLEN-21){imm[20]}}, imm};
  assign jalr_sum   = rs1_val + {{(XLEN-12){imm[11]}}, imm[11:0]};

  always_comb begin
    target = jal_target;
    if (jump_control == `JALR) begin
      target = {jalr_sum[XLEN-1:1], 1'b0};
    end
  end

  assign link = pc + LINK_OFFSET;

`ifdef JUMP_ALIGN_CHECK_EN
  assign misaligned = target[1];
`endif

endmodule

// File: rtl/jump_exec_unit.sv
// rtl/jump_exec_unit.sv - execute-stage jump unit with redirect and link writeback
//
// Purpose: accepts one decoded JAL/JALR at a time, registers the fetch
// redirect and the link writeback, and releases each on its own handshake.
// Ports:
//   clk, rst (sync, active-high)
//   in_valid/in_ready, pc, rs1_val, rd, imm, jump_control : jump input
//   flush                                                  : pipeline kill
//   redirect_valid/redirect_ack, redirect_pc               : fetch redirect
//   wb_valid/wb_ready, wb_rd, wb_data                      : link writeback
//   exc_valid, exc_tval                                    : misaligned target
// Config macro: JUMP_ALIGN_CHECK_EN enables the alignment trap and exc_* ports.

module jump_exec_unit
  import jump_exec_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [4:0]      rd,
  input  logic [20:0]     imm,
  input  logic [1:0]      jump_control,
  input  logic            flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ack,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
`ifdef JUMP_ALIGN_CHECK_EN
  output logic            exc_valid,
  output logic [XLEN-1:0] exc_tval,
`endif
  input  logic            wb_ready
);

  jump_state_t     state_q, state_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            wb_valid_q, wb_valid_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;

  logic [XLEN-1:0] target;
  logic [XLEN-1:0] link;
  logic            accept;

`ifdef JUMP_ALIGN_CHECK_EN
  logic            misaligned;
  logic            exc_valid_q, exc_valid_d;
  logic [XLEN-1:0] exc_tval_q, exc_tval_d;
`endif

  jump_target_calc #(.XLEN(XLEN)) u_calc (
    .pc           (pc),
    .rs1_val      (rs1_val),
    .imm          (imm),
    .jump_control (jump_control),
    .target       (target),
`ifdef JUMP_ALIGN_CHECK_EN
    .misaligned   (misaligned),
`endif
    .link         (link)
  );

  assign in_ready = (state_q == IDLE) && !rst && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d          = state_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    wb_valid_d       = wb_valid_q;
    wb_rd_d          = wb_rd_q;
    wb_data_d        = wb_data_q;
`ifdef JUMP_ALIGN_CHECK_EN
    exc_valid_d      = exc_valid_q;
    exc_tval_d       = exc_tval_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept && is_jump(jump_control)) begin
`ifdef JUMP_ALIGN_CHECK_EN
          if (misaligned) begin
            state_d     = TRAP;
            exc_valid_d = 1'b1;
            exc_tval_d  = target;
          end else begin
`endif
            state_d          = BUSY;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = target;
            wb_valid_d       = (rd != 5'd0);
            wb_rd_d          = rd;
            wb_data_d        = link;
`ifdef JUMP_ALIGN_CHECK_EN
          end
`endif
        end
      end
      BUSY: begin
        if (redirect_valid_q && redirect_ack) redirect_valid_d = 1'b0;
        if (wb_valid_q && wb_ready)           wb_valid_d       = 1'b0;
        if (!redirect_valid_d && !wb_valid_d) state_d          = IDLE;
      end
      default: begin
        // TRAP holds until the trap handler flushes the pipeline.
        state_d = state_q;
      end
    endcase

    // Flush wins over any accept or handshake in the same cycle; payload
    // registers keep their last value.
    if (flush) begin
      state_d          = IDLE;
      redirect_valid_d = 1'b0;
      wb_valid_d       = 1'b0;
`ifdef JUMP_ALIGN_CHECK_EN
      exc_valid_d      = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      wb_valid_q       <= 1'b0;
      wb_rd_q          <= '0;
      wb_data_q        <= '0;
`ifdef JUMP_ALIGN_CHECK_EN
      exc_valid_q      <= 1'b0;
      exc_tval_q       <= '0;
`endif
    end else begin
      state_q          <= state_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      wb_valid_q       <= wb_valid_d;
      wb_rd_q          <= wb_rd_d;
      wb_data_q        <= wb_data_d;
`ifdef JUMP_ALIGN_CHECK_EN
      exc_valid_q      <= exc_valid_d;
      exc_tval_q       <= exc_tval_d;
`endif
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign wb_valid       = wb_valid_q;
  assign wb_rd          = wb_rd_q;
  assign wb_data        = wb_data_q;
`ifdef JUMP_ALIGN_CHECK_EN
  assign exc_valid      = exc_valid_q;
  assign exc_tval       = exc_tval_q;
`endif

endmodule
